// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and
// load writeback, with a registered write stage and per-register busy bits.
module reg_write_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REGS  = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 freeze,
    input  logic                 req0_valid,
    input  logic [ADDR_W-1:0]    req0_reg,
    input  logic [WORD_SIZE-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [ADDR_W-1:0]    req1_reg,
    input  logic [WORD_SIZE-1:0] req1_data,
    output logic                 req1_ready,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_reg,
    output logic [WORD_SIZE-1:0] wr_data,
    output logic [NUM_REGS-1:0]  busy,
    output logic                 last_grant
);

    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_reg_q, wr_reg_d;
    logic [WORD_SIZE-1:0] wr_data_q, wr_data_d;
    logic                 last_q, last_d;
    logic                 pick0, pick1;
    logic                 grant0, grant1;

    // On contention the requester that did not win last time goes first.
    assign pick0  = req0_valid && (!req1_valid || last_q);
    assign pick1  = req1_valid && (!req0_valid || !last_q);
    assign grant0 = reset_n && !freeze && pick0;
    assign grant1 = reset_n && !freeze && pick1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        wr_en_d   = grant0 || grant1;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        last_d    = last_q;
        if (grant0) begin
            wr_reg_d  = req0_reg;
            wr_data_d = req0_data;
            last_d    = 1'b0;
        end else if (grant1) begin
            wr_reg_d  = req1_reg;
            wr_data_d = req1_data;
            last_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            last_q    <= 1'b1;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            busy[k] = wr_en_q && (wr_reg_q == ADDR_W'(k));
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_reg     = wr_reg_q;
    assign wr_data    = wr_data_q;
    assign last_grant = last_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios then random traffic,
// checked against a rule-level arbitration and register-file model.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        freeze;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_reg, req1_reg;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        wr_en;
    logic [1:0]  wr_reg;
    logic [15:0] wr_data;
    logic [3:0]  busy;
    logic        last_grant;

    logic [15:0] rf [4] = '{default: 16'h0};

    int          vecs = 0;
    int          fails = 0;

    int          m_last;
    logic        m_wen;
    logic [1:0]  m_wreg;
    logic [15:0] m_wdata;
    logic [15:0] exp_rf [4];
    logic        saw0, saw1;
    int          cnt0, cnt1;

    reg_write_arbiter #(
        .WORD_SIZE(16),
        .NUM_REGS(4),
        .ADDR_W(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .freeze(freeze),
        .req0_valid(req0_valid),
        .req0_reg(req0_reg),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_reg(req1_reg),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .wr_en(wr_en),
        .wr_reg(wr_reg),
        .wr_data(wr_data),
        .busy(busy),
        .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    // Register file stand-in, written from the DUT's write port.
    always @(posedge clk) begin
        if (wr_en) rf[wr_reg] <= wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = 1;
        m_wen   = 1'b0;
        m_wreg  = 2'd0;
        m_wdata = 16'h0;
    endtask

    // One clock: inputs are already driven (just after a negedge).
    task automatic cycle();
        int         win;
        logic [3:0] bexp;
        win = -1;
        if (!freeze) begin
            if (req0_valid && req1_valid) win = 1 - m_last;
            else if (req0_valid)          win = 0;
            else if (req1_valid)          win = 1;
        end
        #1;
        chk("req0_ready", 32'(req0_ready), 32'(win == 0));
        chk("req1_ready", 32'(req1_ready), 32'(win == 1));
        saw0 = req0_ready;
        saw1 = req1_ready;
        @(posedge clk);
        if (m_wen) exp_rf[m_wreg] = m_wdata;
        if (win >= 0) begin
            m_wen   = 1'b1;
            m_wreg  = (win == 1) ? req1_reg : req0_reg;
            m_wdata = (win == 1) ? req1_data : req0_data;
            m_last  = win;
        end else begin
            m_wen = 1'b0;
        end
        #1;
        bexp = m_wen ? (4'b0001 << m_wreg) : 4'b0000;
        chk("wr_en", 32'(wr_en), 32'(m_wen));
        chk("wr_reg", 32'(wr_reg), 32'(m_wreg));
        chk("wr_data", 32'(wr_data), 32'(m_wdata));
        chk("last_grant", 32'(last_grant), 32'(m_last));
        chk("busy", 32'(busy), 32'(bexp));
        @(negedge clk);
    endtask

    task automatic drop_granted();
        if (saw0) req0_valid = 1'b0;
        if (saw1) req1_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) exp_rf[i] = 16'h0;
        model_reset();
        reset_n    = 1'b0;
        freeze     = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_reg   = 2'd0;
        req1_reg   = 2'd0;
        req0_data  = 16'h0;
        req1_data  = 16'h0;
        #12;
        chk("rst_ready0", 32'(req0_ready), 32'(0));
        chk("rst_ready1", 32'(req1_ready), 32'(0));
        chk("rst_wr_en", 32'(wr_en), 32'(0));
        chk("rst_wr_reg", 32'(wr_reg), 32'(0));
        chk("rst_wr_data", 32'(wr_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_last", 32'(last_grant), 32'(1));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Write pending in the output stage, then reset mid-cycle drops it.
        req1_valid = 1'b1; req1_reg = 2'd3; req1_data = 16'h0077;
        cycle();
        drop_granted();
        req0_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_ready0", 32'(req0_ready), 32'(0));
        chk("mid_rst_last", 32'(last_grant), 32'(1));
        model_reset();
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_dropped", 32'(rf[3]), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Contention: req0 first because last_grant is 1 out of reset.
        req0_valid = 1'b1; req0_reg = 2'd1; req0_data = 16'd5;
        req1_valid = 1'b1; req1_reg = 2'd3; req1_data = 16'hFFF9;
        cycle();
        chk("cont_first_r0", 32'(saw0), 32'(1));
        chk("cont_busy1", 32'(busy), 32'(4'b0010));
        drop_granted();
        cycle();
        chk("cont_second_r1", 32'(saw1), 32'(1));
        chk("cont_busy2", 32'(busy), 32'(4'b1000));
        drop_granted();
        cycle();
        cycle();
        chk("cont_rf1", 32'(rf[1]), 32'(16'd5));
        chk("cont_rf3", 32'(rf[3]), 32'(16'hFFF9));

        // Single requester.
        req0_valid = 1'b1; req0_reg = 2'd2; req0_data = 16'h1234;
        cycle();
        chk("single_busy", 32'(busy), 32'(4'b0100));
        drop_granted();
        cycle();
        chk("single_rf2", 32'(rf[2]), 32'(16'h1234));

        // Same register after a req0 grant: req1 first, req0 lands last.
        req0_valid = 1'b1; req0_reg = 2'd0; req0_data = 16'd10;
        req1_valid = 1'b1; req1_reg = 2'd0; req1_data = 16'd20;
        cycle();
        chk("same_first_r1", 32'(saw1), 32'(1));
        chk("same_busy0_a", 32'(busy[0]), 32'(1));
        drop_granted();
        cycle();
        chk("same_busy0_b", 32'(busy[0]), 32'(1));
        drop_granted();
        cycle();
        chk("same_rf0", 32'(rf[0]), 32'(16'd10));

        // Freeze holds off a request; the grant appears as soon as it falls.
        freeze = 1'b1;
        req1_valid = 1'b1; req1_reg = 2'd1; req1_data = 16'h0055;
        for (int i = 0; i < 3; i++) cycle();
        freeze = 1'b0;
        cycle();
        chk("frz_grant", 32'(saw1), 32'(1));
        drop_granted();
        cycle();
        chk("frz_rf1", 32'(rf[1]), 32'(16'h0055));

        // Freeze raised while a write sits in the output stage.
        req0_valid = 1'b1; req0_reg = 2'd2; req0_data = 16'hBEEF;
        cycle();
        drop_granted();
        freeze = 1'b1;
        req1_valid = 1'b1; req1_reg = 2'd3; req1_data = 16'h0101;
        cycle();
        chk("frz_pending_rf2", 32'(rf[2]), 32'(16'hBEEF));
        freeze = 1'b0;
        cycle();
        drop_granted();

        // Sustained load: both always valid, fresh data after each grant.
        cnt0 = 0; cnt1 = 0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            cnt0 += int'(saw0);
            cnt1 += int'(saw1);
            if (saw0) begin
                req0_reg = 2'($urandom); req0_data = 16'($urandom);
            end
            if (saw1) begin
                req1_reg = 2'($urandom); req1_data = 16'($urandom);
            end
        end
        chk("sust_cnt0", 32'(cnt0), 32'(10));
        chk("sust_cnt1", 32'(cnt1), 32'(10));
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();

        // Random traffic honouring the hold-until-ready rule.
        for (int i = 0; i < 300; i++) begin
            freeze = ($urandom_range(0, 6) == 0);
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_valid = 1'b1;
                req0_reg = 2'($urandom); req0_data = 16'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_valid = 1'b1;
                req1_reg = 2'($urandom); req1_data = 16'($urandom);
            end
            cycle();
            drop_granted();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; freeze = 1'b0;
        cycle();
        cycle();
        for (int k = 0; k < 4; k++) chk("rand_rf", 32'(rf[k]), 32'(exp_rf[k]));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the register file's single write port between two writeback requesters: req0 is ALU writeback and req1 is load/memory writeback. Each cycle the block grants at most one valid request using round-robin priority and latches the winner into a registered output stage. That stage drives the register file's `reg_write`, `write_reg` and `write_data` inputs. It also exports per-register busy bits so decode logic can stall reads of a register whose write has not yet landed.

## Interface
Parameters:
- WORD_SIZE, 16, data width; matches the register file word.
- NUM_REGS, 4, number of architectural registers.
- ADDR_W, 2, register index width; must equal log2(NUM_REGS).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- freeze  in  1  when high, no request is granted this cycle.
- req0_valid  in  1  requester 0 has a write pending.
- req0_reg  in  ADDR_W  requester 0 destination register.
- req0_data  in  WORD_SIZE  requester 0 write data (signed).
- req0_ready  out  1  requester 0 granted this cycle.
- req1_valid, req1_reg, req1_data, req1_ready: same as requester 0, for requester 1.
- wr_en  out  1  to register file `reg_write`.
- wr_reg  out  ADDR_W  to register file `write_reg`.
- wr_data  out  WORD_SIZE  to register file `write_data`.
- busy  out  NUM_REGS  bit k is high while a granted write to register k has not yet been committed.
- last_grant  out  1  index of the most recently granted requester.

## Operation
Handshake:
- A transfer occurs on a rising edge when `reqN_valid && reqN_ready`.
- `reqN_ready` is combinational from the valid inputs, `freeze` and `last_grant`.
- `reqN_ready` never depends on `reqN_data` or `reqN_reg`.
- A requester holds `valid`, `reg` and `data` stable until it sees `ready`.
- At most one `ready` is high in any cycle.

Grant rules, evaluated each cycle:
- `freeze`=1: both ready low.
- Only one requester valid: that requester is granted.
- Both valid: the requester not equal to `last_grant` wins; the loser keeps waiting.
- Neither valid: no grant.
- Two requests to the same register are arbitrated like any other pair. They commit in grant order, so the later grant's data ends up in the register.

State updates on a granted edge:
- `wr_en`<=1.
- `wr_reg`/`wr_data` <= the winner's `reg`/`data`.
- `last_grant`<=winner index.

On any edge with no grant:
- `wr_en`<=0.
- `wr_reg`/`wr_data` hold their previous values.
- `last_grant` holds.

Busy tracking:
- `busy` is combinational: bit `wr_reg` is high iff `wr_en`=1; all other bits are 0.
- The register file commits at the next edge, which clears the bit if no new grant targets the same register.
- Back-to-back grants to the same register keep its bit high continuously.

The output stage never stalls, because the register file accepts a write every cycle. Throughput is therefore one write per cycle.

## Timing
- Reset (async, `reset_n`=0) forces immediately:
  - `wr_en`=0, `wr_reg`=0, `wr_data`=0, `last_grant`=1 (so req0 wins the first contention).
  - `busy`=0 and both `ready`=0 while reset is asserted.
- Reset deassertion: grants may occur on the first rising edge after `reset_n` goes high.
- Reset mid-operation: a write latched in the output stage but not yet committed is dropped. The register file does not see it, because `wr_en` falls asynchronously.
- Latency:
  - Request granted at edge N: `wr_en`=1 during cycle N..N+1, and the register file is updated at edge N+1.
  - The read port shows the new value after edge N+1 (two edges after `valid` is first sampled with ready high).
- `freeze`:
  - Asserted in the cycle of a pending write: the write already in the output stage still commits.
  - From then on, no new write enters until `freeze` falls.
- `ready` responds combinationally to `valid` within the same cycle. There are no registered-ready bubbles.

## Test plan
- Reset: assert `reset_n`=0 mid-cycle with `wr_en`=1 → `wr_en`, `busy` and `ready` drop to 0 without waiting for a clock edge; `last_grant`=1.
- Single requester: req0 writes reg2=16'h1234 → `req0_ready`=1 that cycle, `wr_en`=1 with `wr_reg`=2 and `busy`=4'b0100 the next cycle, register file reads 16'h1234 after the following edge.
- Contention: both valid for 4 cycles (req0→reg1=5, req1→reg3=−7, each dropping valid after its grant) → req0 granted first (`last_grant` was 1), req1 next cycle; `busy` shows 4'b0010 then 4'b1000.
- Same register: both valid targeting reg0 (req0=10, req1=20) after a prior req0 grant → req1 wins first, then req0; reg0 ends at 10; `busy[0]` high for 2 consecutive cycles.
- Freeze: req1 valid with `freeze`=1 for 3 cycles → `req1_ready`=0 and `wr_en`=0 throughout; `freeze` falls → grant in that same cycle, write one edge later.
- Sustained load: both requesters continuously valid for 20 cycles → grants strictly alternate (10 each), `wr_en` high every cycle, no dropped or duplicated writes.
